// File: rtl/complex_writeback_completion_table_pkg.sv
// rtl/complex_writeback_completion_table_pkg.sv - shared types and sizing for the completion table
package complex_writeback_completion_table_pkg;

  localparam int ENTRY_NUM      = 64;
  localparam int DISPATCH_WIDTH = 2;
  localparam int WB_PORTS       = 2;
  localparam int COMMIT_WIDTH   = 2;
  localparam int PTR_W          = $clog2(ENTRY_NUM);

  typedef enum logic [1:0] {
    NOT_FINISHED = 2'd0,
    SUCCESS      = 2'd1,
    REFETCH_THIS = 2'd2,
    REFETCH_NEXT = 2'd3
  } ExecStateCode;

  typedef logic [PTR_W-1:0] CompletionPtr;
  typedef logic [PTR_W:0]   CompletionCount;

  function automatic CompletionCount popcount(input logic [7:0] mask);
    CompletionCount n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + CompletionCount'(mask[i]);
    return n;
  endfunction

  // A prefix mask is a run of ones from bit 0, so adding one carries out of every set bit.
  function automatic logic is_prefix(input logic [7:0] mask);
    return ((mask + 8'd1) & mask) == 8'd0;
  endfunction

endpackage

// File: rtl/completion_state_array.sv
// rtl/completion_state_array.sv - per-entry execution state storage with clear, write and read ports
module completion_state_array
  import complex_writeback_completion_table_pkg::*;
(
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [DISPATCH_WIDTH-1:0]            clr_en_i,
  input  CompletionPtr [DISPATCH_WIDTH-1:0]    clr_ptr_i,
  input  logic [WB_PORTS-1:0]                  wr_en_i,
  input  CompletionPtr [WB_PORTS-1:0]          wr_ptr_i,
  input  logic [WB_PORTS-1:0][1:0]             wr_state_i,
  input  CompletionPtr [COMMIT_WIDTH-1:0]      rd_ptr_i,
  output logic [COMMIT_WIDTH-1:0][1:0]         rd_state_o
);

  logic [1:0] state_q [ENTRY_NUM];

  // Later loop iterations win, so the highest-indexed write port takes a shared pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int e = 0; e < ENTRY_NUM; e++) state_q[e] <= NOT_FINISHED;
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wr_en_i[p]) state_q[wr_ptr_i[p]] <= wr_state_i[p];
      end
      for (int d = 0; d < DISPATCH_WIDTH; d++) begin
        if (clr_en_i[d]) state_q[clr_ptr_i[d]] <= NOT_FINISHED;
      end
    end
  end

  always_comb begin
    rd_state_o = '0;
    for (int r = 0; r < COMMIT_WIDTH; r++) rd_state_o[r] = state_q[rd_ptr_i[r]];
  end

endmodule

// File: rtl/complex_writeback_completion_table.sv
// rtl/complex_writeback_completion_table.sv - in-order completion tracker fed by the complex writeback path
module complex_writeback_completion_table
  import complex_writeback_completion_table_pkg::*;
(
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [DISPATCH_WIDTH-1:0]         alloc_valid_i,
  output logic                              alloc_ready_o,
  output logic [DISPATCH_WIDTH*PTR_W-1:0]   alloc_ptr_o,
  input  logic [WB_PORTS-1:0]               wb_valid_i,
  input  logic [WB_PORTS*PTR_W-1:0]         wb_ptr_i,
  input  logic [WB_PORTS*2-1:0]             wb_state_i,
  output logic [COMMIT_WIDTH-1:0]           commit_valid_o,
  output logic [COMMIT_WIDTH*PTR_W-1:0]     commit_ptr_o,
  output logic [COMMIT_WIDTH*2-1:0]         commit_state_o,
  input  logic [COMMIT_WIDTH-1:0]           commit_ack_i,
  input  logic                              flush_valid_i,
  input  logic [PTR_W-1:0]                  flush_tail_ptr_i,
  input  logic                              flush_all_i,
  output logic [PTR_W:0]                    count_o
);

  CompletionPtr   head_q, head_d, tail_q, tail_d, head_next;
  CompletionCount count_q, count_d, n_commit, n_alloc, flush_span;
  logic           ack_legal, alloc_fire;

  logic [COMMIT_WIDTH-1:0]             cv;
  CompletionPtr [COMMIT_WIDTH-1:0]     rd_ptr;
  logic [COMMIT_WIDTH-1:0][1:0]        rd_state;
  logic [DISPATCH_WIDTH-1:0]           clr_en;
  CompletionPtr [DISPATCH_WIDTH-1:0]   clr_ptr;
  logic [WB_PORTS-1:0]                 wr_en;
  CompletionPtr [WB_PORTS-1:0]         wr_ptr;
  logic [WB_PORTS-1:0][1:0]            wr_state;

  assign wr_ptr   = wb_ptr_i;
  assign wr_state = wb_state_i;

  always_comb begin
    rd_ptr  = '0;
    clr_ptr = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++)   rd_ptr[i]  = head_q + CompletionPtr'(i);
    for (int i = 0; i < DISPATCH_WIDTH; i++) clr_ptr[i] = tail_q + CompletionPtr'(i);
  end

  // Writebacks are filtered against the live range held at the start of the cycle.
  always_comb begin
    wr_en = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      wr_en[p] = wb_valid_i[p] && ({1'b0, CompletionPtr'(wr_ptr[p] - head_q)} < count_q);
    end
  end

  always_comb begin
    logic prev;
    cv   = '0;
    prev = 1'b1;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      cv[i] = prev && (count_q > CompletionCount'(i)) && (rd_state[i] != NOT_FINISHED);
      prev  = cv[i];
    end
  end

  completion_state_array u_state (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_en_i   (clr_en),
    .clr_ptr_i  (clr_ptr),
    .wr_en_i    (wr_en),
    .wr_ptr_i   (wr_ptr),
    .wr_state_i (wr_state),
    .rd_ptr_i   (rd_ptr),
    .rd_state_o (rd_state)
  );

  always_comb begin
    ack_legal  = is_prefix(8'(commit_ack_i)) && ((commit_ack_i & ~cv) == '0);
    n_commit   = ack_legal ? popcount(8'(commit_ack_i)) : '0;
    head_next  = head_q + CompletionPtr'(n_commit);
    alloc_fire = alloc_ready_o && !flush_valid_i && !flush_all_i;
    n_alloc    = alloc_fire ? popcount(8'(alloc_valid_i)) : '0;
    clr_en     = alloc_fire ? alloc_valid_i : '0;
    flush_span = {1'b0, CompletionPtr'(flush_tail_ptr_i - head_next)};
    head_d     = head_next;
    tail_d     = tail_q + CompletionPtr'(n_alloc);
    count_d    = count_q - n_commit + n_alloc;
    if (flush_all_i) begin
      tail_d  = head_next;
      count_d = '0;
    end else if (flush_valid_i) begin
      tail_d  = flush_tail_ptr_i;
      count_d = flush_span;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign alloc_ready_o  = count_q <= CompletionCount'(ENTRY_NUM - DISPATCH_WIDTH);
  assign alloc_ptr_o    = clr_ptr;
  assign commit_valid_o = cv;
  assign commit_ptr_o   = rd_ptr;
  assign commit_state_o = rd_state;
  assign count_o        = count_q;

  a_ack_legal: assert property (@(posedge clk_i) disable iff (rst_i) ack_legal);
  a_alloc_prefix: assert property (@(posedge clk_i) disable iff (rst_i) is_prefix(8'(alloc_valid_i)));
  a_flush_range: assert property (@(posedge clk_i) disable iff (rst_i)
                                  flush_valid_i |-> (flush_span <= count_q - n_commit));

endmodule

// File: doc/complex_writeback_completion_table.md
Name: complex_writeback_completion_table

Overview:
In-order completion tracker and the receiving end of the complex-integer writeback path. Dispatch allocates one entry per op at the tail. Writeback ports mark entries with an execution state, indexed by active-list pointer. The commit side reads finished ops in order from the head. A selective flush rolls the tail back.

Parameters:
ENTRY_NUM, 64, entries in the table; power of two.
DISPATCH_WIDTH, 2, allocations per cycle.
WB_PORTS, 2, writeback ports; equals complex issue width.
COMMIT_WIDTH, 2, in-order commits per cycle.
PTR_W, $clog2(ENTRY_NUM), entry pointer width.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
alloc_valid  in  DISPATCH_WIDTH  allocation request; must be a prefix mask (bit i set implies bits below i set).
alloc_ready  out  1  high when free entries >= DISPATCH_WIDTH.
alloc_ptr  out  DISPATCH_WIDTH*PTR_W  slot i = (tail+i) mod ENTRY_NUM.
wb_valid  in  WB_PORTS  writeback strobe.
wb_ptr  in  WB_PORTS*PTR_W  target entry.
wb_state  in  WB_PORTS*2  exec state: 0 NOT_FINISHED, 1 SUCCESS, 2 REFETCH_THIS, 3 REFETCH_NEXT.
commit_valid  out  COMMIT_WIDTH  head-window entry i is finished; prefix mask.
commit_ptr  out  COMMIT_WIDTH*PTR_W  (head+i) mod ENTRY_NUM.
commit_state  out  COMMIT_WIDTH*2  state of head-window entry i.
commit_ack  in  COMMIT_WIDTH  retire request; must be a prefix mask and a subset of commit_valid.
flush_valid  in  1  keep entries [head, flush_tail_ptr); discard the rest.
flush_tail_ptr  in  PTR_W  new tail.
flush_all  in  1  discard all live entries.
count  out  PTR_W+1  number of live entries.

Behaviour:
- Reset (synchronous): head=0, tail=0, count=0, all states NOT_FINISHED. Outputs: alloc_ready=1, commit_valid=0, count=0. Reset overrides every other input, including in the middle of an operation.
- Live range: [head, head+count) mod ENTRY_NUM. Full: count==ENTRY_NUM. Empty: count==0. Pointers wrap mod ENTRY_NUM.
- Allocation:
  - Requests are accepted only when alloc_ready=1; otherwise they are ignored.
  - On an accepted request, the allocated entries' states become NOT_FINISHED at the next edge and tail advances by popcount(alloc_valid).
  - alloc_ready is computed from the current count; same-cycle commits do not count as free space.
- Writeback:
  - Applied at the next edge only if wb_ptr lies in the live range sampled at the start of the cycle; out-of-range writes (stale after a flush) are dropped.
  - Writing NOT_FINISHED is legal and means replay; it reopens the entry.
  - Two ports targeting the same pointer in one cycle: the higher port index wins.
- Commit:
  - commit_valid[i] = (count>i) && state[head+i]!=NOT_FINISHED && commit_valid[i-1].
  - Outputs are combinational from registered state. Latency: a writeback sampled at edge N is visible on commit_valid after edge N. There is no bypass.
  - head advances by popcount(commit_ack). An illegal ack (non-prefix, or not a subset of commit_valid) is flagged by an assertion and ignored.
- Flush:
  - flush_all: tail<=head_next, count<=0, where head_next is head after same-cycle commits.
  - flush_valid: tail<=flush_tail_ptr, count<=(flush_tail_ptr-head_next) mod ENTRY_NUM. flush_tail_ptr==head_next means empty.
  - flush_tail_ptr must lie in [head_next, tail]; an assertion checks this.
  - Flush beats same-cycle allocation: the allocation is dropped.
  - Same-cycle writebacks into discarded entries are harmless; reallocation clears their state.
- Simultaneous events, in order: commit, then flush, then allocation; writebacks use the old live range.
- Commit and allocation in the same cycle: count_next = count + allocs - commits.

Decomposition:
- Shared package: ExecStateCode enum (2 bits), CompletionPtr typedef (PTR_W), CompletionCount typedef (PTR_W+1), ENTRY_NUM constant.
- Sub-module: completion_state_array. Holds the ENTRY_NUM x 2-bit registers with DISPATCH_WIDTH clear ports and WB_PORTS write ports (priority to higher index), plus COMMIT_WIDTH combinational read ports.
- Top level holds head, tail and count, plus the commit, flush and allocation arithmetic.

Test Plan:
- Reset, then allocate 2 per cycle for 3 cycles -> alloc_ptr {0,1},{2,3},{4,5}; count=6; commit_valid=0.
- Write SUCCESS to ptr 1, then to ptr 0 one cycle later -> commit_valid=00 until ptr 0 is written, then 11 on the following cycle with commit_state {1,1}; ack 11 -> count=4.
- Fill to 64 entries -> alloc_ready=0 and further allocs ignored; commit 2 in the same cycle as an alloc request -> alloc still ignored, next cycle alloc_ready=1.
- Wrap: head=62, tail=62, allocate 4 -> alloc_ptr {62,63} then {0,1}; write SUCCESS to all four -> commit_ptr {62,63} then {0,1}.
- Live entries 10..19: flush_valid with flush_tail_ptr=14 plus a writeback to ptr 17 -> count=4, tail=14; next alloc_ptr {14,15} with state NOT_FINISHED.
- Both ports write ptr 5 in one cycle (port0 SUCCESS, port1 REFETCH_THIS) -> commit_state=2; assert reset mid-burst -> next cycle count=0, commit_valid=0.
